// File: rtl/tt_um_ir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_ir_sequencer
//  Description : Six-T-state control sequencer for a simple accumulator CPU.
//                Common fetch in T1-T3, opcode decode in T4-T6, with a sticky
//                HALT state. Emits the control word on uo_out/uio_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_ir_sequencer (
    input  logic       clk,
    input  logic       rst_n,     // active-high synchronous reset (pinout name)
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        ST_T1   = 3'b001,
        ST_T2   = 3'b010,
        ST_T3   = 3'b011,
        ST_T4   = 3'b100,
        ST_T5   = 3'b101,
        ST_T6   = 3'b110,
        ST_HALT = 3'b111
    } state_t;

    localparam logic [3:0] C_OP_LDA = 4'h0;
    localparam logic [3:0] C_OP_ADD = 4'h1;
    localparam logic [3:0] C_OP_SUB = 4'h2;
    localparam logic [3:0] C_OP_OUT = 4'hE;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    state_t     r_state;
    logic [3:0] r_opcode;

    logic       w_step_en;
    logic [3:0] w_op_live;
    logic       w_ctrl_en;

    // Individual control bits before gating
    logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea;
    logic w_su, w_eu, w_lb, w_lo;

    // Operand address, unused bidir inputs and ena are intentionally ignored
    logic w_unused;
    assign w_unused = &{1'b0, ena, uio_in[7:1], ui_in[3:0]};

    assign w_step_en = uio_in[0];
    assign w_op_live = ui_in[7:4];

    // Controls only fire when the sequencer is actually advancing out of reset
    assign w_ctrl_en = ~rst_n & w_step_en;

    // State and latched opcode; T4 captures the live opcode for T5/T6 decode
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state  <= ST_T1;
            r_opcode <= 4'h0;
        end else if (w_step_en) begin
            case (r_state)
                ST_T1:   r_state <= ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3:   r_state <= ST_T4;
                ST_T4: begin
                    if (w_op_live == C_OP_HLT) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state  <= ST_T5;
                        r_opcode <= w_op_live;
                    end
                end
                ST_T5:   r_state <= ST_T6;
                ST_T6:   r_state <= ST_T1;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_T1;
            endcase
        end
    end

    // Control-word decode: T4 looks at the live IR, T5/T6 at the latched opcode
    always_comb begin
        w_cp = 1'b0; w_ep = 1'b0; w_lm = 1'b0; w_ce = 1'b0;
        w_li = 1'b0; w_ei = 1'b0; w_la = 1'b0; w_ea = 1'b0;
        w_su = 1'b0; w_eu = 1'b0; w_lb = 1'b0; w_lo = 1'b0;
        case (r_state)
            ST_T1: begin
                w_ep = 1'b1;
                w_lm = 1'b1;
            end
            ST_T2: w_cp = 1'b1;
            ST_T3: begin
                w_ce = 1'b1;
                w_li = 1'b1;
            end
            ST_T4: begin
                case (w_op_live)
                    C_OP_LDA, C_OP_ADD, C_OP_SUB: begin
                        w_ei = 1'b1;
                        w_lm = 1'b1;
                    end
                    C_OP_OUT: begin
                        w_ea = 1'b1;
                        w_lo = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (r_opcode)
                    C_OP_LDA: begin
                        w_ce = 1'b1;
                        w_la = 1'b1;
                    end
                    C_OP_ADD, C_OP_SUB: begin
                        w_ce = 1'b1;
                        w_lb = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (r_opcode)
                    C_OP_ADD: begin
                        w_eu = 1'b1;
                        w_la = 1'b1;
                    end
                    C_OP_SUB: begin
                        w_su = 1'b1;
                        w_eu = 1'b1;
                        w_la = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign uo_out  = w_ctrl_en ? {w_ea, w_la, w_ei, w_li, w_ce, w_lm, w_ep, w_cp}
                               : 8'h00;
    assign uio_out = {r_state,
                      (w_ctrl_en ? {w_lo, w_lb, w_eu, w_su} : 4'b0000),
                      1'b0};
    assign uio_oe  = 8'hFE;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_ir_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tt_um_ir_sequencer
//  Description : Directed self-checking bench for tt_um_ir_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_ir_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    tt_um_ir_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Bus-driver exclusivity, sampled mid-cycle
    always @(negedge clk) begin
        if (ena) begin
            total++;
            if ($countones({uo_out[1], uo_out[3], uo_out[5], uo_out[7], uio_out[2]}) > 1) begin
                bad++;
                $display("FAIL bus_excl uo_out=%h uio_out=%h (at most one driver required)", uo_out, uio_out);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset through one edge, release it; DUT is then in T1
    task automatic apply_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; uio_in = 8'h01; ui_in = 8'hF0;
        tick();
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h20 || uio_oe !== 8'hFE) begin
            bad++;
            $display("FAIL reset_state got uo=%h uio=%h oe=%h exp uo=00 uio=20 oe=FE", uo_out, uio_out, uio_oe);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h06 || uio_out !== 8'h20) begin
            bad++;
            $display("FAIL reset_first_t1 got uo=%h uio=%h exp uo=06 uio=20", uo_out, uio_out);
        end
    endtask

    task automatic test_lda();
        logic [7:0] e_uo  [7] = '{8'h06, 8'h01, 8'h18, 8'h24, 8'h48, 8'h00, 8'h06};
        logic [7:0] e_uio [7] = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'h20};
        ui_in = 8'h05; uio_in = 8'h01;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            total++;
            if (uo_out !== e_uo[i] || uio_out !== e_uio[i]) begin
                bad++;
                $display("FAIL lda_cycle%0d got uo=%h uio=%h exp uo=%h uio=%h", i, uo_out, uio_out, e_uo[i], e_uio[i]);
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_sub();
        ui_in = 8'h2A; uio_in = 8'h01;
        apply_reset();
        repeat (3) tick();
        total++;
        if (uo_out !== 8'h24 || uio_out !== 8'h80) begin
            bad++;
            $display("FAIL sub_t4 got uo=%h uio=%h exp uo=24 uio=80", uo_out, uio_out);
        end
        tick();
        total++;
        if (uo_out !== 8'h08 || uio_out !== 8'hA8) begin
            bad++;
            $display("FAIL sub_t5 got uo=%h uio=%h exp uo=08 uio=A8", uo_out, uio_out);
        end
        tick();
        total++;
        if (uo_out !== 8'h40 || uio_out !== 8'hC6) begin
            bad++;
            $display("FAIL sub_t6 got uo=%h uio=%h exp uo=40 uio=C6", uo_out, uio_out);
        end
    endtask

    // ADD seen at T4, IR changes afterwards (including during a stall in T5)
    task automatic test_capture();
        ui_in = 8'h13; uio_in = 8'h01;
        apply_reset();
        repeat (4) tick();
        ui_in = 8'h27;
        #1;
        total++;
        if (uo_out !== 8'h08 || uio_out !== 8'hA8) begin
            bad++;
            $display("FAIL cap_t5 got uo=%h uio=%h exp uo=08 uio=A8", uo_out, uio_out);
        end
        uio_in = 8'h00;
        repeat (3) tick();
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'hA0) begin
            bad++;
            $display("FAIL cap_stall got uo=%h uio=%h exp uo=00 uio=A0", uo_out, uio_out);
        end
        uio_in = 8'h01;
        tick();
        total++;
        if (uo_out !== 8'h40 || uio_out !== 8'hC4) begin
            bad++;
            $display("FAIL cap_t6_add got uo=%h uio=%h exp uo=40 uio=C4", uo_out, uio_out);
        end
    endtask

    task automatic test_out_nop();
        logic [7:0] e_uio [3] = '{8'h80, 8'hA0, 8'hC0};
        logic [7:0] e_uo  [3] = '{8'h80, 8'h00, 8'h00};
        ui_in = 8'hE0; uio_in = 8'h01;
        apply_reset();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (uo_out !== e_uo[i] || uio_out !== (e_uio[i] | (i == 0 ? 8'h10 : 8'h00))) begin
                bad++;
                $display("FAIL out_t%0d got uo=%h uio=%h exp uo=%h", i + 4, uo_out, uio_out, e_uo[i]);
            end
            tick();
        end
        // NOP opcode 3: no controls in T4-T6, normal wrap to T1
        ui_in = 8'h35;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (uo_out !== 8'h00 || uio_out !== e_uio[i]) begin
                bad++;
                $display("FAIL nop_t%0d got uo=%h uio=%h exp uo=00 uio=%h", i + 4, uo_out, uio_out, e_uio[i]);
            end
            tick();
        end
        total++;
        if (uo_out !== 8'h06 || uio_out !== 8'h20) begin
            bad++;
            $display("FAIL nop_wrap got uo=%h uio=%h exp uo=06 uio=20", uo_out, uio_out);
        end
    endtask

    task automatic test_halt();
        int errs = 0;
        ui_in = 8'hF0; uio_in = 8'h01;
        apply_reset();
        repeat (3) tick();
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h80) begin
            bad++;
            $display("FAIL hlt_t4 got uo=%h uio=%h exp uo=00 uio=80", uo_out, uio_out);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (uo_out !== 8'h00 || uio_out !== 8'hE0) begin
                bad++;
                $display("FAIL halt_hold%0d got uo=%h uio=%h exp uo=00 uio=E0", i, uo_out, uio_out);
            end
            ui_in  = 8'($urandom);
            uio_in = {7'($urandom), 1'($urandom_range(0, 1))};
            #1;
        end
        // Reset must win even with step_en low
        uio_in = 8'h00;
        rst_n = 1'b1;
        tick();
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h20) begin
            bad++;
            $display("FAIL halt_reset got uo=%h uio=%h exp uo=00 uio=20", uo_out, uio_out);
        end
        rst_n = 1'b0; uio_in = 8'h01;
        #1;
        total++;
        if (uo_out !== 8'h06 || uio_out !== 8'h20) begin
            bad++;
            $display("FAIL halt_restart got uo=%h uio=%h exp uo=06 uio=20", uo_out, uio_out);
        end
    endtask

    task automatic test_stall();
        ui_in = 8'h05; uio_in = 8'h01;
        apply_reset();
        repeat (2) tick();
        uio_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (uo_out !== 8'h00 || uio_out !== 8'h60) begin
                bad++;
                $display("FAIL stall%0d got uo=%h uio=%h exp uo=00 uio=60", i, uo_out, uio_out);
            end
            tick();
        end
        uio_in = 8'h01;
        #1;
        total++;
        if (uo_out !== 8'h18 || uio_out !== 8'h60) begin
            bad++;
            $display("FAIL stall_resume got uo=%h uio=%h exp uo=18 uio=60", uo_out, uio_out);
        end
        tick();
        total++;
        if (uo_out !== 8'h24 || uio_out !== 8'h80) begin
            bad++;
            $display("FAIL stall_t4 got uo=%h uio=%h exp uo=24 uio=80", uo_out, uio_out);
        end
    endtask

    task automatic test_reset_mid();
        ui_in = 8'h10; uio_in = 8'h01;
        apply_reset();
        repeat (4) tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'hA0) begin
            bad++;
            $display("FAIL mid_rst_gate got uo=%h uio=%h exp uo=00 uio=A0", uo_out, uio_out);
        end
        tick();
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h20) begin
            bad++;
            $display("FAIL mid_rst_edge got uo=%h uio=%h exp uo=00 uio=20", uo_out, uio_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (uo_out !== 8'h06 || uio_out !== 8'h20) begin
            bad++;
            $display("FAIL mid_rst_t1 got uo=%h uio=%h exp uo=06 uio=20", uo_out, uio_out);
        end
        tick();
        total++;
        if (uo_out !== 8'h01 || uio_out !== 8'h40) begin
            bad++;
            $display("FAIL mid_rst_t2 got uo=%h uio=%h exp uo=01 uio=40", uo_out, uio_out);
        end
    endtask

    initial begin
        ena = 1'b1; rst_n = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        test_reset();
        test_lda();
        test_sub();
        test_capture();
        test_out_nop();
        test_halt();
        test_stall();
        test_reset_mid();
        ena = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_um_ir_sequencer.md
TT_UM_IR_SEQUENCER -- requirements
Module: tt_um_ir_sequencer

Interface
REQ-001: clk  input  1  sole clock; all state updates on rising edge.
REQ-002: rst_n  input  1  reset, synchronous and active-high (asserted = 1; port name kept per top-level pinout convention).
REQ-003: ui_in  input  8  current instruction register contents; [7:4] opcode, [3:0] operand address (not decoded).
REQ-004: uo_out  output  8  control word low byte: [0] CP pc-increment, [1] EP pc-to-bus, [2] LM load-MAR, [3] CE RAM-to-bus, [4] LI load-IR, [5] EI IR-address-to-bus, [6] LA load-A, [7] EA A-to-bus.
REQ-005: uio_in  input  8  [0] step_en (1 = sequencer advances); [7:1] ignored.
REQ-006: uio_out  output  8  [0] constant 0, [1] SU subtract, [2] EU ALU-to-bus, [3] LB load-B, [4] LO load-output, [7:5] T-state code.
REQ-007: uio_oe  output  8  constant 8'hFE.
REQ-008: ena  input  1  ignored.

Function
REQ-009: State register SHALL hold one of T1..T6 (codes 3'b001..3'b110) or HALT (3'b111); code 3'b000 SHALL never occur.
REQ-010: uio_out[7:5] SHALL always equal the current state code.
REQ-011: With step_en=1 and reset deasserted, transitions SHALL be T1->T2->T3->T4->T5->T6->T1, one per clock.
REQ-012: In T4, if ui_in[7:4]=4'hF, next state SHALL be HALT instead of T5.
REQ-013: HALT SHALL persist regardless of step_en or ui_in until reset.
REQ-014: With step_en=0, state and captured opcode SHALL hold, and every control bit (uo_out[7:0], uio_out[4:1]) SHALL be 0.
REQ-015: Control bits SHALL be combinational from state (and opcode) and SHALL be 0 in any state/opcode not listed below.
REQ-016: Fetch (all opcodes): T1 EP,LM; T2 CP; T3 CE,LI.
REQ-017: T4 decode SHALL use live ui_in[7:4]; on the T4->T5 edge ui_in[7:4] SHALL be captured into opcode_q, and T5/T6 decode SHALL use opcode_q only.
REQ-018: LDA (4'h0): T4 EI,LM; T5 CE,LA; T6 none.
REQ-019: ADD (4'h1): T4 EI,LM; T5 CE,LB; T6 EU,LA.
REQ-020: SUB (4'h2): T4 EI,LM; T5 CE,LB; T6 SU,EU,LA.
REQ-021: OUT (4'hE): T4 EA,LO; T5, T6 none.
REQ-022: HLT (4'hF): T4 none; HALT all control bits 0.
REQ-023: Any other opcode SHALL be NOP: T4-T6 no control bits, normal sequencing.
REQ-024: At most one bus driver (EP, CE, EI, EA, EU) SHALL be asserted in any cycle.

Reset
REQ-025: While rst_n=1, all control bits SHALL be 0 irrespective of state or step_en.
REQ-026: Clock edge with rst_n=1 SHALL set state T1 and opcode_q 4'h0, including from HALT or mid-instruction; reset SHALL take priority over step_en.
REQ-027: Post-reset outputs (rst_n=1 held through one edge): uo_out=8'h00, uio_out=8'h20, uio_oe=8'hFE.
REQ-028: First cycle after reset deassertion with step_en=1 SHALL be T1 (uo_out=8'h06).

Verification
REQ-029: Reset, step_en=1, ui_in=8'h05 (LDA) -> uo_out per cycle 06,01,18,24,48,00, then 06; uio_out[7:5] 1..6 then 1.
REQ-030: ui_in=8'h2A (SUB) -> T5 uo_out=08, uio_out=A8; T6 uo_out=40, uio_out=C6.
REQ-031: ui_in=8'h1x during T4, changed to 8'h2x during T5 -> T6 uio_out=C4 (ADD; SU not asserted).
REQ-032: ui_in=8'hE0 (OUT) -> T4 uo_out=80, uio_out=90; ui_in=8'hF0 (HLT) -> T4 all controls 0, then uio_out=E0, uo_out=00 held for 20 cycles; reset -> T1.
REQ-033: step_en=0 during T3 for 5 cycles -> uo_out=00, uio_out=60 held; step_en=1 -> uo_out=18, then T4 next clock.
REQ-034: Reset asserted during T5 of ADD -> next edge uio_out=20, uo_out=00; deassert -> T1 fetch restarts, opcode_q=0.
